// File: rtl/mem_pkg.sv
// Shared codes for the load/store alignment stage: request sizes, extender
// width codes, fault codes and the FSM state type.
package mem_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    localparam logic [2:0] EC_WORD = 3'b000;
    localparam logic [2:0] EC_HALF = 3'b001;
    localparam logic [2:0] EC_BYTE = 3'b010;

    localparam logic [1:0] FLT_NONE     = 2'b00;
    localparam logic [1:0] FLT_MISALIGN = 2'b01;
    localparam logic [1:0] FLT_TIMEOUT  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Size code 11 behaves as a word everywhere downstream.
    function automatic logic [2:0] size_to_ec(input logic [1:0] size);
        logic [2:0] ec;
        case (size)
            SZ_HALF: ec = EC_HALF;
            SZ_BYTE: ec = EC_BYTE;
            default: ec = EC_WORD;
        endcase
        return ec;
    endfunction

endpackage

// File: rtl/mem_align_unit_if.sv
// Request, data-bus and response signals of the load/store alignment stage.
// The master modport is the alignment unit; slave is the core/memory side.
interface mem_align_unit_if;
    import mem_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_sign;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [2:0]  rsp_ec;
    logic        rsp_sign;
    logic [1:0]  rsp_fault;
    logic        stall;

    modport master (
        input  req_valid, req_we, req_size, req_sign, req_addr, req_wdata,
        output req_ready,
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata,
        output rsp_valid, rsp_data, rsp_ec, rsp_sign, rsp_fault, stall
    );

    modport slave (
        output req_valid, req_we, req_size, req_sign, req_addr, req_wdata,
        input  req_ready,
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata,
        input  rsp_valid, rsp_data, rsp_ec, rsp_sign, rsp_fault, stall
    );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte enables, store-data replication,
// right-justified load data and misalignment detection (little-endian lanes).
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [31:0] rdata_sh_s;

    assign rdata_sh_s = rdata_i >> {lane_i, 3'b000};

    // Per-size lane selection; unknown size code falls through to word.
    always_comb begin
        be_o       = 4'b1111;
        wdata_o    = wdata_i;
        rdata_o    = rdata_sh_s;
        misalign_o = 1'b0;
        case (size_i)
            SZ_BYTE: begin
                be_o       = 4'b0001 << lane_i;
                wdata_o    = {4{wdata_i[7:0]}};
                rdata_o    = {24'h000000, rdata_sh_s[7:0]};
                misalign_o = 1'b0;
            end
            SZ_HALF: begin
                be_o       = 4'b0011 << {lane_i[1], 1'b0};
                wdata_o    = {2{wdata_i[15:0]}};
                rdata_o    = {16'h0000, rdata_sh_s[15:0]};
                misalign_o = lane_i[0];
            end
            default: begin
                be_o       = 4'b1111;
                wdata_o    = wdata_i;
                rdata_o    = rdata_sh_s;
                misalign_o = (lane_i != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_align_unit.sv
// Load/store access stage: accepts one request, runs a single word-aligned
// bus transaction with timeout, and returns a one-cycle response pulse.
module mem_align_unit
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic             clk,
    input logic             rst_n,
    mem_align_unit_if.master io
);

    localparam int unsigned    CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e             state_q;
    logic               lat_we_q;
    logic [1:0]         lat_size_q;
    logic               lat_sign_q;
    logic [1:0]         lat_lane_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               req_ready_q;
    logic               bus_req_q;
    logic               bus_we_q;
    logic [31:0]        bus_addr_q;
    logic [3:0]         bus_be_q;
    logic [31:0]        bus_wdata_q;
    logic               rsp_valid_q;
    logic [31:0]        rsp_data_q;
    logic [2:0]         rsp_ec_q;
    logic               rsp_sign_q;
    logic [1:0]         rsp_fault_q;

    logic               accept_s;
    logic [1:0]         al_size_s;
    logic [1:0]         al_lane_s;
    logic [3:0]         be_s;
    logic [31:0]        wdata_rep_s;
    logic [31:0]        rdata_al_s;
    logic               misalign_s;

    assign accept_s = io.req_valid & req_ready_q;

    // In IDLE the aligner looks at the incoming request; afterwards it works
    // from the latched fields so that the load data is steered correctly.
    assign al_size_s = (state_q == ST_IDLE) ? io.req_size     : lat_size_q;
    assign al_lane_s = (state_q == ST_IDLE) ? io.req_addr[1:0] : lat_lane_q;

    mem_lane_align u_lane_align (
        .size_i     (al_size_s),
        .lane_i     (al_lane_s),
        .wdata_i    (io.req_wdata),
        .rdata_i    (io.bus_rdata),
        .be_o       (be_s),
        .wdata_o    (wdata_rep_s),
        .rdata_o    (rdata_al_s),
        .misalign_o (misalign_s)
    );

    // Access FSM with timeout counter, request latches and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            lat_we_q    <= 1'b0;
            lat_size_q  <= 2'b00;
            lat_sign_q  <= 1'b0;
            lat_lane_q  <= 2'b00;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0000_0000;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= 32'h0000_0000;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'h0000_0000;
            rsp_ec_q    <= EC_WORD;
            rsp_sign_q  <= 1'b0;
            rsp_fault_q <= FLT_NONE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        lat_we_q    <= io.req_we;
                        lat_size_q  <= io.req_size;
                        lat_sign_q  <= io.req_sign;
                        lat_lane_q  <= io.req_addr[1:0];
                        cnt_q       <= '0;
                        req_ready_q <= 1'b0;
                        if (misalign_s) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= 32'h0000_0000;
                            rsp_ec_q    <= size_to_ec(io.req_size);
                            rsp_sign_q  <= io.req_sign;
                            rsp_fault_q <= FLT_MISALIGN;
                        end else begin
                            state_q     <= ST_BUS;
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= io.req_we;
                            bus_addr_q  <= {io.req_addr[31:2], 2'b00};
                            bus_be_q    <= be_s;
                            bus_wdata_q <= wdata_rep_s;
                        end
                    end
                end
                ST_BUS: begin
                    // Ack wins over timeout when both land on the last cycle.
                    if (io.bus_ack) begin
                        state_q     <= ST_RESP;
                        bus_req_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= lat_we_q ? 32'h0000_0000 : rdata_al_s;
                        rsp_ec_q    <= size_to_ec(lat_size_q);
                        rsp_sign_q  <= lat_sign_q;
                        rsp_fault_q <= FLT_NONE;
                    end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                        state_q     <= ST_RESP;
                        bus_req_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= 32'h0000_0000;
                        rsp_ec_q    <= size_to_ec(lat_size_q);
                        rsp_sign_q  <= lat_sign_q;
                        rsp_fault_q <= FLT_TIMEOUT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RESP: begin
                    state_q     <= ST_IDLE;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    bus_req_q   <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign io.req_ready = req_ready_q;
    assign io.stall     = ~req_ready_q;
    assign io.bus_req   = bus_req_q;
    assign io.bus_we    = bus_we_q;
    assign io.bus_addr  = bus_addr_q;
    assign io.bus_be    = bus_be_q;
    assign io.bus_wdata = bus_wdata_q;
    assign io.rsp_valid = rsp_valid_q;
    assign io.rsp_data  = rsp_data_q;
    assign io.rsp_ec    = rsp_ec_q;
    assign io.rsp_sign  = rsp_sign_q;
    assign io.rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_mem_align_unit.sv
// Bench for mem_align_unit (timeout of 4 cycles): directed table from the
// access rules, random transactions against an arithmetic model, reset cases.
module tb_mem_align_unit;

    localparam int TMO = 4;

    logic clk;
    logic rst_n;

    mem_align_unit_if io ();

    mem_align_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ackd;        // BUS cycle index where ack is shown, -1 never
        int          exp_cycles;  // cycles bus_req is high
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_data;
        logic [2:0]  exp_ec;
        logic [1:0]  exp_fault;
    } vec_t;

    int n_vec;
    int n_err;
    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference behaviour from the access rules, written with plain arithmetic.
    function automatic vec_t model(input vec_t v);
        vec_t   r;
        int     lane;
        int     nb;
        longint shifted;
        r    = v;
        lane = int'(v.addr % 32'd4);
        nb   = (v.size == 2'd2) ? 1 : ((v.size == 2'd1) ? 2 : 4);
        r.exp_addr = v.addr - (v.addr % 32'd4);
        if (nb == 1) begin
            r.exp_be    = 4'(1 << lane);
            r.exp_wdata = (v.wdata % 32'd256) * 32'h0101_0101;
            r.exp_ec    = 3'd2;
        end else if (nb == 2) begin
            r.exp_be    = 4'(3 << (lane - (lane % 2)));
            r.exp_wdata = (v.wdata % 32'd65536) * 32'h0001_0001;
            r.exp_ec    = 3'd1;
        end else begin
            r.exp_be    = 4'd15;
            r.exp_wdata = v.wdata;
            r.exp_ec    = 3'd0;
        end
        shifted = longint'(v.rdata) / (64'd1 << (8 * lane));
        if ((lane % nb) != 0) begin
            r.exp_cycles = 0;
            r.exp_fault  = 2'd1;
            r.exp_data   = 32'd0;
        end else if (v.ackd >= 0 && v.ackd < TMO) begin
            r.exp_cycles = v.ackd + 1;
            r.exp_fault  = 2'd0;
            r.exp_data   = v.we ? 32'd0 : 32'(shifted % (64'd1 << (8 * nb)));
        end else begin
            r.exp_cycles = TMO;
            r.exp_fault  = 2'd2;
            r.exp_data   = 32'd0;
        end
        return r;
    endfunction

    task automatic run_txn(input vec_t v, input string name);
        int c;
        bit done;
        @(negedge clk);
        chk({name, ".req_ready"}, {31'd0, io.req_ready}, 32'd1);
        io.req_valid = 1'b1;
        io.req_we    = v.we;
        io.req_size  = v.size;
        io.req_sign  = v.sign;
        io.req_addr  = v.addr;
        io.req_wdata = v.wdata;
        @(negedge clk);
        io.req_valid = 1'b0;
        io.req_we    = ~v.we;
        io.req_size  = 2'($urandom);
        io.req_sign  = ~v.sign;
        io.req_addr  = $urandom;
        io.req_wdata = $urandom;
        c    = 0;
        done = 1'b0;
        while (!done && c < 40) begin
            if (io.rsp_valid === 1'b1) begin
                done = 1'b1;
            end else begin
                if (v.exp_cycles > 0 && (c == 0 || c == v.exp_cycles - 1)) begin
                    chk({name, ".bus_req"},   {31'd0, io.bus_req}, 32'd1);
                    chk({name, ".bus_we"},    {31'd0, io.bus_we}, {31'd0, v.we});
                    chk({name, ".bus_addr"},  io.bus_addr, v.exp_addr);
                    chk({name, ".bus_be"},    {28'd0, io.bus_be}, {28'd0, v.exp_be});
                    chk({name, ".bus_wdata"}, io.bus_wdata, v.exp_wdata);
                    chk({name, ".stall"},     {31'd0, io.stall}, 32'd1);
                end
                if (c == v.ackd) begin
                    io.bus_ack   = 1'b1;
                    io.bus_rdata = v.rdata;
                end
                @(negedge clk);
                io.bus_ack   = 1'b0;
                io.bus_rdata = $urandom;
                c++;
            end
        end
        chk({name, ".rsp_seen"},   {31'd0, done}, 32'd1);
        chk({name, ".bus_cycles"}, c, v.exp_cycles);
        chk({name, ".bus_req_off"}, {31'd0, io.bus_req}, 32'd0);
        chk({name, ".rsp_data"},   io.rsp_data, v.exp_data);
        chk({name, ".rsp_ec"},     {29'd0, io.rsp_ec}, {29'd0, v.exp_ec});
        chk({name, ".rsp_sign"},   {31'd0, io.rsp_sign}, {31'd0, v.sign});
        chk({name, ".rsp_fault"},  {30'd0, io.rsp_fault}, {30'd0, v.exp_fault});
        @(negedge clk);
        chk({name, ".rsp_pulse"},  {31'd0, io.rsp_valid}, 32'd0);
        chk({name, ".ready_back"}, {31'd0, io.req_ready}, 32'd1);
        chk({name, ".rsp_hold"},   io.rsp_data, v.exp_data);
    endtask

    initial begin
        vec_t v;
        n_vec = 0;
        n_err = 0;
        // we size sign addr wdata rdata ackd | cycles addr be wdata data ec fault
        tbl[0] = '{1'b0, 2'b10, 1'b1, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 3,
                   4, 32'h0000_1000, 4'b1000, 32'h0, 32'h0000_0080, 3'b010, 2'b00};
        tbl[1] = '{1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h1234_ABCD, 32'hDEAD_BEEF, 1,
                   2, 32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 32'h0, 3'b001, 2'b00};
        tbl[2] = '{1'b0, 2'b00, 1'b0, 32'h0000_3001, 32'h0, 32'h1111_1111, 0,
                   0, 32'h0, 4'b0000, 32'h0, 32'h0, 3'b000, 2'b01};
        tbl[3] = '{1'b0, 2'b00, 1'b1, 32'h0000_5000, 32'h0, 32'h2222_2222, -1,
                   4, 32'h0000_5000, 4'b1111, 32'h0, 32'h0, 3'b000, 2'b10};
        tbl[4] = '{1'b0, 2'b01, 1'b0, 32'h0000_4002, 32'h0, 32'hFEDC_1234, 0,
                   1, 32'h0000_4000, 4'b1100, 32'h0, 32'h0000_FEDC, 3'b001, 2'b00};
        tbl[5] = '{1'b0, 2'b10, 1'b0, 32'h0000_6001, 32'h0, 32'h1122_3344, 0,
                   1, 32'h0000_6000, 4'b0010, 32'h0, 32'h0000_0033, 3'b010, 2'b00};
        tbl[6] = '{1'b1, 2'b10, 1'b0, 32'h0000_7002, 32'h0000_00A5, 32'h0, 2,
                   3, 32'h0000_7000, 4'b0100, 32'hA5A5_A5A5, 32'h0, 3'b010, 2'b00};
        tbl[7] = '{1'b0, 2'b11, 1'b1, 32'h0000_8000, 32'h0, 32'hCAFE_F00D, 2,
                   3, 32'h0000_8000, 4'b1111, 32'h0, 32'hCAFE_F00D, 3'b000, 2'b00};
        tbl[8] = '{1'b1, 2'b01, 1'b1, 32'h0000_9003, 32'h5555_6666, 32'h0, 0,
                   0, 32'h0, 4'b0000, 32'h0, 32'h0, 3'b001, 2'b01};
        tbl[9] = '{1'b0, 2'b01, 1'b0, 32'h0000_9000, 32'h0, 32'h1234_ABCD, 1,
                   2, 32'h0000_9000, 4'b0011, 32'h0, 32'h0000_ABCD, 3'b001, 2'b00};

        rst_n        = 1'b0;
        io.req_valid = 1'b0;
        io.req_we    = 1'b0;
        io.req_size  = 2'b00;
        io.req_sign  = 1'b0;
        io.req_addr  = 32'h0;
        io.req_wdata = 32'h0;
        io.bus_ack   = 1'b0;
        io.bus_rdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst.req_ready", {31'd0, io.req_ready}, 32'd1);
        chk("rst.stall",     {31'd0, io.stall}, 32'd0);
        chk("rst.bus_req",   {31'd0, io.bus_req}, 32'd0);
        chk("rst.bus_we",    {31'd0, io.bus_we}, 32'd0);
        chk("rst.bus_addr",  io.bus_addr, 32'd0);
        chk("rst.bus_be",    {28'd0, io.bus_be}, 32'd0);
        chk("rst.bus_wdata", io.bus_wdata, 32'd0);
        chk("rst.rsp_valid", {31'd0, io.rsp_valid}, 32'd0);
        chk("rst.rsp_data",  io.rsp_data, 32'd0);
        chk("rst.rsp_ec",    {29'd0, io.rsp_ec}, 32'd0);
        chk("rst.rsp_sign",  {31'd0, io.rsp_sign}, 32'd0);
        chk("rst.rsp_fault", {30'd0, io.rsp_fault}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_txn(tbl[i], $sformatf("tbl%0d", i));
        end

        // Stray ack after the timeout entry must not produce a response.
        run_txn(tbl[3], "tmo_again");
        io.bus_ack   = 1'b1;
        io.bus_rdata = 32'hBAD0_BAD0;
        repeat (3) begin
            @(negedge clk);
            chk("stray.rsp_valid", {31'd0, io.rsp_valid}, 32'd0);
            chk("stray.bus_req",   {31'd0, io.bus_req}, 32'd0);
            chk("stray.req_ready", {31'd0, io.req_ready}, 32'd1);
        end
        io.bus_ack = 1'b0;

        // Reset while a load is waiting on the bus.
        @(negedge clk);
        io.req_valid = 1'b1;
        io.req_we    = 1'b0;
        io.req_size  = 2'b00;
        io.req_addr  = 32'h0000_A000;
        @(negedge clk);
        io.req_valid = 1'b0;
        chk("rstbus.bus_req_on", {31'd0, io.bus_req}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rstbus.bus_req",   {31'd0, io.bus_req}, 32'd0);
        chk("rstbus.req_ready", {31'd0, io.req_ready}, 32'd1);
        io.bus_ack   = 1'b1;
        io.bus_rdata = 32'h1234_5678;
        repeat (6) begin
            @(negedge clk);
            chk("rstbus.no_rsp", {31'd0, io.rsp_valid}, 32'd0);
        end
        io.bus_ack = 1'b0;

        // Random transactions against the model.
        for (int i = 0; i < 60; i++) begin
            v.we    = 1'($urandom);
            v.size  = 2'($urandom);
            v.sign  = 1'($urandom);
            v.addr  = $urandom;
            v.wdata = $urandom;
            v.rdata = $urandom;
            v.ackd  = int'($urandom_range(0, 5));
            v = model(v);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_txn(v, $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
